// File: rtl/shift_seq_unit.sv
// Multi-cycle SLL/SRA sequencer: shifts a captured operand by up to STEP bits per
// cycle under a start/busy/done handshake and holds the registered result.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | waiting for start; operand/shamt/op captured on the start edge
//  SHIFT | shifting acc by min(remaining, STEP) each cycle
//  DONE  | result valid; done pulses for this single cycle
module shift_seq_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand,
    input  logic [4:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [5:0] STEP_K = 6'(STEP);

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         acc_q, acc_d;
    logic [5:0]               rem_q, rem_d;
    logic                     op_q, op_d;
    logic [WIDTH-1:0]         result_d;
    logic                     busy_d, done_d;
    logic [5:0]               k;
    logic signed [WIDTH-1:0]  sra_v;
    logic [WIDTH-1:0]         shifted;

    // The arithmetic shift sits in its own signed net: inside a ternary with an
    // unsigned arm it would silently degrade to a logical shift.
    assign k       = (rem_q > STEP_K) ? STEP_K : rem_q;
    assign sra_v   = $signed(acc_q) >>> k;
    assign shifted = op_q ? $unsigned(sra_v) : (acc_q << k);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= 1'b0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            result  <= result_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        op_d     = op_q;
        result_d = result;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = operand;
                    rem_d = {1'b0, shamt};
                    op_d  = op;
                    if (shamt == 5'd0) begin
                        result_d = operand;
                        state_d  = DONE;
                    end else begin
                        state_d  = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = shifted;
                rem_d = rem_q - k;
                if (rem_q == k) begin
                    result_d = shifted;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flags are registered from the next state so they align with state_q.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

endmodule
